apb_access_guard: RTL and testbench

Parametrised APB access guard between the APB master and the memory slave. It checks every transfer against NUM_REGIONS address windows, the bus alignment, and per-region write protection. Offending transfers are blocked from the memory and completed locally with pslverr; legal transfers pass through unchanged. It also keeps sticky error status, a first-error capture and a saturating error counter for software and debug.

---
 rtl/apb_guard_pkg.sv | 20 ++
 rtl/apb_region_dec.sv | 56 +++++
 rtl/apb_access_guard.sv | 149 ++++++++++++++
 tb/tb_apb_access_guard.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_guard_pkg.sv
// rtl/apb_guard_pkg.sv - shared types and constants for the APB access guard
package apb_guard_pkg;

  typedef struct packed {
    logic wp;
    logic misalign;
    logic oob;
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } guard_state_t;

  localparam int ERR_OOB = 0;
  localparam int ERR_MIS = 1;
  localparam int ERR_WP  = 2;

endpackage

// File: rtl/apb_region_dec.sv
// rtl/apb_region_dec.sv - combinational region match and error-code decode for one APB address
module apb_region_dec
  import apb_guard_pkg::*;
#(
  parameter int                      ADDR_W        = 32,
  parameter int                      DATA_W        = 64,
  parameter int                      NUM_REGIONS   = 2,
  parameter logic [ADDR_W-1:0]       REGION_BASE [NUM_REGIONS] = '{32'h0000_0000, 32'h0001_0000},
  parameter int unsigned             REGION_SIZE_K [NUM_REGIONS] = '{64, 64},
  parameter logic [NUM_REGIONS-1:0]  REGION_RO     = 2'b10,
  parameter int                      IDX_W         = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  output err_code_t         code_o,
  output logic [IDX_W-1:0]  match_idx_o
);

  // Extra 11 bits keep base + size*1024 from wrapping at the top of the address space.
  localparam int                EW         = ADDR_W + 11;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);

  logic [EW-1:0] addr_ext;
  logic [EW-1:0] lo;
  logic [EW-1:0] hi;
  logic          hit;
  logic          ro;

  assign addr_ext = EW'(paddr_i);

  always_comb begin
    hit         = 1'b0;
    ro          = 1'b0;
    lo          = '0;
    hi          = '0;
    match_idx_o = '0;
    // Walk from the top index down so the lowest-index match is the one left standing.
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      lo = EW'(REGION_BASE[i]);
      hi = lo + (EW'(REGION_SIZE_K[i]) << 10);
      if (addr_ext >= lo && addr_ext < hi) begin
        hit         = 1'b1;
        ro          = REGION_RO[i];
        match_idx_o = IDX_W'(i);
      end
    end
  end

  always_comb begin
    code_o          = '0;
    code_o.oob      = !hit;
    code_o.misalign = (paddr_i & ALIGN_MASK) != '0;
    code_o.wp       = pwrite_i & hit & ro;
  end

endmodule

// File: rtl/apb_access_guard.sv
// rtl/apb_access_guard.sv - APB guard: blocks out-of-window, misaligned and write-protected
// transfers, completes them locally with pslverr and logs them.
module apb_access_guard
  import apb_guard_pkg::*;
#(
  parameter int                      ADDR_W        = 32,
  parameter int                      DATA_W        = 64,
  parameter int                      NUM_REGIONS   = 2,
  parameter logic [ADDR_W-1:0]       REGION_BASE [NUM_REGIONS] = '{32'h0000_0000, 32'h0001_0000},
  parameter int unsigned             REGION_SIZE_K [NUM_REGIONS] = '{64, 64},
  parameter logic [NUM_REGIONS-1:0]  REGION_RO     = 2'b10,
  parameter int                      CNT_W         = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              pready,
  output logic              pslverr,
  output logic              s_psel,
  output logic              s_penable,
  input  logic              s_pready,
  input  logic              s_pslverr,
  input  logic              err_clr,
  output logic [2:0]        err_status,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [2:0]        err_code,
  output logic              err_write,
  output logic [CNT_W-1:0]  err_count
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  err_code_t          code;
  logic [IDX_W-1:0]   unused_match_idx;

  guard_state_t       state_q, state_d;
  err_code_t          err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;

  logic [2:0]         status_q, status_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  eaddr_q, eaddr_d;
  err_code_t          ecode_q, ecode_d;
  logic               ewrite_q, ewrite_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               setup_now;
  logic               access_now;
  logic               guard_err;
  logic               guard_done;

  apb_region_dec #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .NUM_REGIONS   (NUM_REGIONS),
    .REGION_BASE   (REGION_BASE),
    .REGION_SIZE_K (REGION_SIZE_K),
    .REGION_RO     (REGION_RO),
    .IDX_W         (IDX_W)
  ) u_dec (
    .paddr_i     (paddr),
    .pwrite_i    (pwrite),
    .code_o      (code),
    .match_idx_o (unused_match_idx)
  );

  // state_q is the phase of the previous cycle; the current phase follows from it and the bus.
  assign setup_now  = psel & !penable;
  assign access_now = psel & penable & (state_q == SETUP || state_q == ACCESS);
  assign guard_err  = err_q != '0;
  assign guard_done = access_now & guard_err;

  assign s_psel    = psel & (setup_now ? (code == '0) : (access_now & !guard_err));
  assign s_penable = penable & s_psel;
  assign pready    = access_now & (guard_err | s_pready);
  assign pslverr   = access_now & (guard_err | s_pslverr);

  always_comb begin
    state_d = IDLE;
    if (setup_now) begin
      state_d = SETUP;
    end else if (access_now && !pready) begin
      state_d = ACCESS;
    end
  end

  // A clear in the same cycle as a completion is applied first, then the new error is logged.
  always_comb begin
    status_d = err_clr ? '0 : status_q;
    valid_d  = err_clr ? 1'b0 : valid_q;
    eaddr_d  = err_clr ? '0 : eaddr_q;
    ecode_d  = err_clr ? '0 : ecode_q;
    ewrite_d = err_clr ? 1'b0 : ewrite_q;
    count_d  = err_clr ? '0 : count_q;
    if (guard_done) begin
      status_d = status_d | err_q;
      if (count_d != '1) begin
        count_d = count_d + CNT_W'(1);
      end
      if (!valid_d) begin
        valid_d  = 1'b1;
        eaddr_d  = addr_q;
        ecode_d  = err_q;
        ewrite_d = write_q;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      err_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      status_q <= '0;
      valid_q  <= 1'b0;
      eaddr_q  <= '0;
      ecode_q  <= '0;
      ewrite_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (setup_now) begin
        err_q   <= code;
        addr_q  <= paddr;
        write_q <= pwrite;
      end
      status_q <= status_d;
      valid_q  <= valid_d;
      eaddr_q  <= eaddr_d;
      ecode_q  <= ecode_d;
      ewrite_q <= ewrite_d;
      count_q  <= count_d;
    end
  end

  assign err_status = status_q;
  assign err_valid  = valid_q;
  assign err_addr   = eaddr_q;
  assign err_code   = {ecode_q.wp, ecode_q.misalign, ecode_q.oob};
  assign err_write  = ewrite_q;
  assign err_count  = count_q;

endmodule

// File: tb/tb_apb_access_guard.sv
// tb/tb_apb_access_guard.sv - directed self-checking bench for apb_access_guard
module tb_apb_access_guard;

  logic        pclk;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic        s_pready, s_pslverr;
  logic        err_clr;

  logic        pready, pslverr, s_psel, s_penable;
  logic [2:0]  err_status, err_code;
  logic        err_valid, err_write;
  logic [31:0] err_addr;
  logic [15:0] err_count;

  logic        pready2, pslverr2, s_psel2, s_penable2;
  logic [2:0]  err_status2, err_code2;
  logic        err_valid2, err_write2;
  logic [31:0] err_addr2;
  logic [1:0]  err_count2;

  int n_chk;
  int n_fail;

  apb_access_guard dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pready(pready), .pslverr(pslverr), .s_psel(s_psel),
    .s_penable(s_penable), .s_pready(s_pready), .s_pslverr(s_pslverr), .err_clr(err_clr),
    .err_status(err_status), .err_valid(err_valid), .err_addr(err_addr),
    .err_code(err_code), .err_write(err_write), .err_count(err_count)
  );

  apb_access_guard #(.CNT_W(2)) dut2 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pready(pready2), .pslverr(pslverr2), .s_psel(s_psel2),
    .s_penable(s_penable2), .s_pready(s_pready), .s_pslverr(s_pslverr), .err_clr(err_clr),
    .err_status(err_status2), .err_valid(err_valid2), .err_addr(err_addr2),
    .err_code(err_code2), .err_write(err_write2), .err_count(err_count2)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    tick();
    psel = 1'b0; penable = 1'b0; err_clr = 1'b0; s_pready = 1'b0; s_pslverr = 1'b0;
    #3;
  endtask

  task automatic legal_xfer(input logic [31:0] addr, input logic wr, input int waits, input logic slv);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; s_pready = 1'b0; s_pslverr = 1'b0;
    #3;
    n_chk++; if (s_psel !== 1'b1) begin n_fail++; $display("FAIL legal_setup_s_psel addr=%h: got %b expected 1", addr, s_psel); end
    n_chk++; if ({s_penable, pready} !== 2'b00) begin n_fail++; $display("FAIL legal_setup_pen_rdy addr=%h: got %b expected 00", addr, {s_penable, pready}); end
    tick();
    penable = 1'b1;
    for (int w = 0; w < waits; w++) begin
      s_pready = 1'b0;
      #3;
      n_chk++; if ({s_psel, s_penable, pready} !== 3'b110) begin n_fail++; $display("FAIL legal_wait addr=%h: got %b expected 110", addr, {s_psel, s_penable, pready}); end
      tick();
    end
    s_pready = 1'b1; s_pslverr = slv;
    #3;
    n_chk++; if ({s_penable, pready, pslverr} !== {2'b11, slv}) begin n_fail++; $display("FAIL legal_access addr=%h: got %b expected %b", addr, {s_penable, pready, pslverr}, {2'b11, slv}); end
  endtask

  task automatic err_xfer(input logic [31:0] addr, input logic wr, input logic clr);
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; s_pready = 1'b0; s_pslverr = 1'b0;
    #3;
    n_chk++; if (s_psel !== 1'b0) begin n_fail++; $display("FAIL err_setup_s_psel addr=%h: got %b expected 0", addr, s_psel); end
    tick();
    penable = 1'b1; err_clr = clr;
    #3;
    n_chk++; if ({pready, pslverr, s_psel, s_penable} !== 4'b1100) begin n_fail++; $display("FAIL err_access addr=%h: got %b expected 1100", addr, {pready, pslverr, s_psel, s_penable}); end
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    tick();
    tick();
    #3;
    n_chk++; if ({pready, pslverr, s_psel, s_penable} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {pready, pslverr, s_psel, s_penable}); end
    n_chk++; if ({err_status, err_valid, err_code, err_write} !== 8'h00 || err_addr !== 32'h0 || err_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_logs: status=%b valid=%b code=%b write=%b addr=%h count=%0d expected all 0", err_status, err_valid, err_code, err_write, err_addr, err_count);
    end
    tick();
    presetn = 1'b1;
  endtask

  task automatic test_legal_read();
    legal_xfer(32'h0000_0008, 1'b0, 1, 1'b0);
    idle();
    legal_xfer(32'h0000_0008, 1'b0, 0, 1'b1);
    idle();
    n_chk++; if ({err_valid, err_count} !== 17'h0) begin n_fail++; $display("FAIL legal_no_log: valid=%b count=%0d expected 0/0", err_valid, err_count); end
  endtask

  task automatic test_wp_write();
    err_xfer(32'h0001_0000, 1'b1, 1'b0);
    idle();
    n_chk++; if ({err_valid, err_code, err_write} !== 5'b1_100_1) begin n_fail++; $display("FAIL wp_capture: got %b expected 11001", {err_valid, err_code, err_write}); end
    n_chk++; if (err_addr !== 32'h0001_0000) begin n_fail++; $display("FAIL wp_addr: got %h expected 00010000", err_addr); end
    n_chk++; if (err_status !== 3'b100 || err_count !== 16'd1) begin n_fail++; $display("FAIL wp_status_count: got %b/%0d expected 100/1", err_status, err_count); end
  endtask

  task automatic test_oob_misaligned();
    tick();
    err_clr = 1'b1;
    idle();
    n_chk++; if ({err_status, err_valid, err_code} !== 7'h0 || err_count !== 16'd0 || err_addr !== 32'h0) begin
      n_fail++; $display("FAIL clr_idle: status=%b valid=%b code=%b count=%0d addr=%h expected all 0", err_status, err_valid, err_code, err_count, err_addr);
    end
    err_xfer(32'h0002_0003, 1'b0, 1'b0);
    idle();
    n_chk++; if ({err_code, err_status, err_write} !== 7'b011_011_0) begin n_fail++; $display("FAIL oob_mis_code: got %b expected 0110110", {err_code, err_status, err_write}); end
    n_chk++; if (err_addr !== 32'h0002_0003 || err_count !== 16'd1) begin n_fail++; $display("FAIL oob_mis_addr_count: got %h/%0d expected 00020003/1", err_addr, err_count); end
  endtask

  task automatic test_second_error();
    err_xfer(32'h0001_0000, 1'b1, 1'b0);
    idle();
    n_chk++; if (err_addr !== 32'h0002_0003 || err_code !== 3'b011 || err_write !== 1'b0) begin n_fail++; $display("FAIL second_kept: addr=%h code=%b write=%b expected 00020003/011/0", err_addr, err_code, err_write); end
    n_chk++; if (err_status !== 3'b111 || err_count !== 16'd2 || err_count2 !== 2'd2) begin n_fail++; $display("FAIL second_status_count: got %b/%0d/%0d expected 111/2/2", err_status, err_count, err_count2); end
  endtask

  task automatic test_saturation();
    tick();
    err_clr = 1'b1;
    idle();
    for (int k = 0; k < 5; k++) begin
      err_xfer(32'h0003_0000, 1'b0, 1'b0);
      idle();
    end
    n_chk++; if (err_count !== 16'd5) begin n_fail++; $display("FAIL sat_count16: got %0d expected 5", err_count); end
    n_chk++; if (err_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_count2: got %0d expected 3", err_count2); end
    n_chk++; if (err_status !== 3'b001 || err_code !== 3'b001) begin n_fail++; $display("FAIL sat_status_code: got %b/%b expected 001/001", err_status, err_code); end
  endtask

  task automatic test_clr_collision();
    err_xfer(32'h0000_0004, 1'b0, 1'b1);
    idle();
    n_chk++; if (err_count !== 16'd1 || err_count2 !== 2'd1) begin n_fail++; $display("FAIL collide_count: got %0d/%0d expected 1/1", err_count, err_count2); end
    n_chk++; if ({err_status, err_valid, err_code} !== 7'b010_1_010) begin n_fail++; $display("FAIL collide_status: got %b expected 0101010", {err_status, err_valid, err_code}); end
    n_chk++; if (err_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL collide_addr: got %h expected 00000004", err_addr); end
  endtask

  task automatic test_back_to_back();
    legal_xfer(32'h0000_0010, 1'b1, 0, 1'b0);
    err_xfer(32'h0002_0000, 1'b0, 1'b0);
    idle();
    n_chk++; if (err_status !== 3'b011 || err_count !== 16'd2 || err_code !== 3'b010) begin n_fail++; $display("FAIL b2b_log: got %b/%0d/%b expected 011/2/010", err_status, err_count, err_code); end
  endtask

  task automatic test_boundaries();
    legal_xfer(32'h0001_FFF8, 1'b0, 1, 1'b0);
    idle();
    legal_xfer(32'h0000_FFF8, 1'b1, 0, 1'b1);
    idle();
    n_chk++; if (err_count !== 16'd2 || err_status !== 3'b011) begin n_fail++; $display("FAIL bound_no_log: got %0d/%b expected 2/011", err_count, err_status); end
  endtask

  task automatic test_psel_drop();
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0001_0000;
    #3;
    n_chk++; if (s_psel !== 1'b0) begin n_fail++; $display("FAIL drop_s_psel: got %b expected 0", s_psel); end
    idle();
    n_chk++; if (pready !== 1'b0 || err_count !== 16'd2) begin n_fail++; $display("FAIL drop_no_log: got %b/%0d expected 0/2", pready, err_count); end
  endtask

  task automatic test_reset_mid();
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0003_0000;
    tick();
    penable = 1'b1;
    #3;
    n_chk++; if (pready !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 1", pready); end
    presetn = 1'b0;
    #1;
    n_chk++; if ({pready, pslverr, s_psel, s_penable} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_outputs: got %b expected 0000", {pready, pslverr, s_psel, s_penable}); end
    n_chk++; if ({err_status, err_valid} !== 4'b0 || err_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_logs: got %b/%b/%0d expected 0", err_status, err_valid, err_count); end
    tick();
    psel = 1'b0; penable = 1'b0;
    tick();
    presetn = 1'b1;
    tick();
    tick();
    #3;
    n_chk++; if ({err_status, err_valid, err_code} !== 7'h0 || err_count !== 16'd0 || err_addr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_after: status=%b valid=%b code=%b count=%0d addr=%h expected 0", err_status, err_valid, err_code, err_count, err_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    s_pready = 1'b0; s_pslverr = 1'b0; err_clr = 1'b0;
    test_reset();
    test_legal_read();
    test_wp_write();
    test_oob_misaligned();
    test_second_error();
    test_saturation();
    test_clr_collision();
    test_back_to_back();
    test_boundaries();
    test_psel_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
